sdr_wr_buf: RTL

- Upstream stage of the SDRAM write engine: accepts one user write command plus its data stream.
- Stages the data in an 8-deep show-ahead FIFO.
- Issues a single-cycle write request with the byte count and bank/row/column address to the write engine.
- Serves the engine's data reads using the FIFO fill level.
- One transaction is in flight at a time; the next command is accepted only after the engine reports exit.

---
 rtl/sdr_wr_buf_pkg.sv | 29 ++
 rtl/sdr_wfifo.sv | 60 ++++++
 rtl/sdr_wr_buf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sdr_wr_buf_pkg.sv
// Shared definitions for the SDRAM write-buffer front end: FSM states,
// FIFO sizing, user address field layout and error-flag bit indices.
package sdr_wr_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 8;
    localparam int DEPTH_W    = 4;

    // usr_wr_addr = {bank, row, col}
    localparam int ADDR_W  = 24;
    localparam int BA_W    = 2;
    localparam int ROW_W   = 13;
    localparam int COL_W   = 9;
    localparam int COL_LSB = 0;
    localparam int ROW_LSB = COL_LSB + COL_W;
    localparam int BA_LSB  = ROW_LSB + ROW_W;

    localparam int ERR_W          = 3;
    localparam int ERR_RD_EMPTY   = 0;
    localparam int ERR_EARLY_EXIT = 1;
    localparam int ERR_RD_IDLE    = 2;

endpackage

// File: rtl/sdr_wfifo.sv
// Show-ahead data FIFO: registered storage, head word presented combinationally,
// occupancy counter 0..DEPTH, synchronous flush.
module sdr_wfifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int CNTW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DW-1:0]   din,
    input  logic            pop,
    input  logic            flush,
    output logic [DW-1:0]   dout,
    output logic [CNTW-1:0] depth
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] cnt;
    logic            do_push;
    logic            do_pop;

    // A full FIFO refuses a push even when a pop frees a slot the same cycle.
    assign do_push = push && (cnt < CNTW'(DEPTH));
    assign do_pop  = pop && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNTW'(1);
                2'b01:   cnt <= cnt - CNTW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by cnt alone,
    // which keeps the array a plain RAM with no reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = (cnt == '0) ? '0 : mem[rd_ptr];
    assign depth = cnt;

endmodule

// File: rtl/sdr_wr_buf.sv
// SDRAM write-buffer front end: accepts one user write command, stages its data
// in sdr_wfifo and feeds the write engine. Optional macro: SDR_WR_BUF_ERR_EN.
module sdr_wr_buf #(
    parameter int FIFO_DEPTH = sdr_wr_buf_pkg::FIFO_DEPTH,
    parameter int DW         = 16,
    parameter int LENW       = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               usr_wr_req,
    input  logic [sdr_wr_buf_pkg::ADDR_W-1:0]  usr_wr_addr,
    input  logic [LENW-1:0]                    usr_wr_len,
    output logic                               usr_wr_ack,
    input  logic                               usr_wdata_vld,
    input  logic [DW-1:0]                      usr_wdata,
    output logic                               usr_wdata_rdy,
    output logic                               sdr_wr_req,
    output logic [LENW-1:0]                    sdr_wr_byte_cnt,
    output logic [sdr_wr_buf_pkg::BA_W-1:0]    sdr_bank_addr,
    output logic [sdr_wr_buf_pkg::ROW_W-1:0]   sdr_row_addr,
    output logic [sdr_wr_buf_pkg::COL_W-1:0]   sdr_col_addr,
    output logic [sdr_wr_buf_pkg::DEPTH_W-1:0] sdr_wdata_filled_depth,
    input  logic                               sdr_wdata_rd,
    output logic [DW-1:0]                      sdr_wdata,
    input  logic                               wr_exit,
    output logic                               wr_busy
`ifdef SDR_WR_BUF_ERR_EN
    ,
    output logic [sdr_wr_buf_pkg::ERR_W-1:0]   err_flags
`endif
);

    import sdr_wr_buf_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [LENW-1:0]      push_cnt;
    logic [DEPTH_W-1:0]   depth;
    logic                 cmd_accept;
    logic                 push;
    logic                 pop;
    logic                 flush;

    assign cmd_accept = (state == IDLE) && usr_wr_req;
    assign push       = usr_wdata_vld && usr_wdata_rdy;
    assign pop        = sdr_wdata_rd && (state == BUSY);
    assign flush      = (state == DONE);
    assign wr_busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        usr_wr_ack    = 1'b0;
        sdr_wr_req    = 1'b0;
        usr_wdata_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (usr_wr_req) begin
                    usr_wr_ack = 1'b1;
                    if (usr_wr_len != '0) state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                sdr_wr_req = 1'b1;
                state_nxt  = BUSY;
            end
            BUSY: begin
                usr_wdata_rdy = (push_cnt < sdr_wr_byte_cnt) &&
                                (depth < DEPTH_W'(FIFO_DEPTH));
                if (wr_exit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdr_wr_byte_cnt <= '0;
            sdr_bank_addr   <= '0;
            sdr_row_addr    <= '0;
            sdr_col_addr    <= '0;
        end else if (cmd_accept) begin
            sdr_wr_byte_cnt <= usr_wr_len;
            sdr_bank_addr   <= usr_wr_addr[BA_LSB +: BA_W];
            sdr_row_addr    <= usr_wr_addr[ROW_LSB +: ROW_W];
            sdr_col_addr    <= usr_wr_addr[COL_LSB +: COL_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      push_cnt <= '0;
        else if (cmd_accept || flush) push_cnt <= '0;
        else if (push)                push_cnt <= push_cnt + LENW'(1);
    end

    sdr_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW),
        .CNTW  (DEPTH_W)
    ) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (usr_wdata),
        .pop   (pop),
        .flush (flush),
        .dout  (sdr_wdata),
        .depth (depth)
    );

    assign sdr_wdata_filled_depth = depth;

`ifdef SDR_WR_BUF_ERR_EN
    // Sticky protocol-violation flags; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
        end else begin
            if (sdr_wdata_rd && (depth == '0))
                err_flags[ERR_RD_EMPTY] <= 1'b1;
            if ((state == BUSY) && wr_exit &&
                ((push_cnt < sdr_wr_byte_cnt) || (depth != '0)))
                err_flags[ERR_EARLY_EXIT] <= 1'b1;
            if (sdr_wdata_rd && (state != BUSY))
                err_flags[ERR_RD_IDLE] <= 1'b1;
        end
    end
`endif

endmodule
